// File: rtl/stage_mem_lsu.sv
// MEM-stage load/store unit: runs LB/LBU/LH/LHU/LW/SB/SH/SW byte by byte
// over the shared 8-bit memory port, stalling the pipeline until retire.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global run enable (low = freeze everything)
//   valid_i           EX/MEM holds a valid instruction
//   opcode_i          instruction opcode (load / store / other)
//   funct3_i          [1:0] access size (0=B,1=H,2=W), [2] unsigned
//   wd_i, wreg_i      destination register and its write enable
//   wdata_i           EX result, passed through for non-memory ops
//   mem_addr_i        effective byte address
//   store_data_i      rs2 value for stores
//   mem_gnt_i         memctrl grants the port this cycle
//   mem_data_i        read byte, valid RD_LAT cycles after issue
//   wd_o, wreg_o      destination register / write enable to MEM/WB
//   wdata_o           writeback data
//   stall_req_o       hold IF..EX/MEM
//   mem_req_o         port request to memctrl
//   mem_we_o          write strobe, only asserted together with grant
//   mem_addr_o        byte address
//   mem_data_o        write byte
module stage_mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_data_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              stall_req_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o
);

    localparam int NB    = XLEN / 8;
    localparam int CNT_W = $clog2(NB + 1);

    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    // Access context latched at accept
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  size;
    logic              uns;
    logic              store;
    logic [XLEN-1:0]   sdata;
    logic [4:0]        wd_q;

    logic [CNT_W-1:0]  iss_cnt;
    logic [CNT_W-1:0]  cap_cnt;
    logic [RD_LAT-1:0] vpipe;
    logic [XLEN-1:0]   rbuf;

    logic              is_load;
    logic              is_store;
    logic              accept;
    logic              pending;
    logic              issue;
    logic              capture;
    logic [CNT_W-1:0]  dec_size;
    logic [7:0]        st_byte;
    logic [XLEN-1:0]   ld_val;
    logic              sign;

    assign is_load  = (opcode_i == LOAD_OP);
    assign is_store = (opcode_i == STORE_OP);
    assign accept   = (state == IDLE) && valid_i && (is_load || is_store);
    assign pending  = (iss_cnt < size);

    // A beat leaves the port only on a granted, running XFER cycle
    assign issue   = (state == XFER) && rdy && mem_gnt_i && pending;
    // Oldest tag in the read pipe marks the byte arriving this cycle
    assign capture = (state == XFER) && !store && vpipe[RD_LAT-1];

    // Unarchitected encodings collapse to a single byte
    always_comb begin
        dec_size = CNT_W'(1);
        unique case (funct3_i)
            3'd1:    dec_size = CNT_W'(2);
            3'd2:    dec_size = CNT_W'(4);
            3'd5:    dec_size = is_load ? CNT_W'(2) : CNT_W'(1);
            default: dec_size = CNT_W'(1);
        endcase
    end

    always_comb begin
        st_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (iss_cnt == CNT_W'(i)) begin
                st_byte = sdata[8*i +: 8];
            end
        end
    end

    // Bytes beyond the access size are filled from bit 8N-1 unless unsigned
    always_comb begin
        sign = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (size == CNT_W'(i + 1)) begin
                sign = rbuf[8*i + 7];
            end
        end
        ld_val = '0;
        for (int i = 0; i < NB; i++) begin
            if (CNT_W'(i) < size) begin
                ld_val[8*i +: 8] = rbuf[8*i +: 8];
            end else begin
                ld_val[8*i +: 8] = {8{sign & ~uns}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        unique case (state)
            IDLE: begin
                if (valid_i && !(is_load || is_store)) begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end
                if (accept) begin
                    stall_req_o = 1'b1;
                    state_nx    = XFER;
                end
            end
            XFER: begin
                stall_req_o = 1'b1;
                mem_req_o   = rdy && pending;
                mem_addr_o  = base + ADDR_W'(iss_cnt);
                if (store) begin
                    mem_data_o = st_byte;
                    mem_we_o   = rdy && mem_gnt_i && pending;
                end
                if (store && issue && (iss_cnt == size - CNT_W'(1))) begin
                    state_nx = DONE;
                end
                if (capture && (cap_cnt == size - CNT_W'(1))) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!store) begin
                    wreg_o  = 1'b1;
                    wd_o    = wd_q;
                    wdata_o = ld_val;
                end
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Reset cycle drives nothing, so an aborted store cannot strobe
        if (rst) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = '0;
            stall_req_o = 1'b0;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_data_o  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base    <= '0;
            size    <= '0;
            uns     <= 1'b0;
            store   <= 1'b0;
            sdata   <= '0;
            wd_q    <= '0;
            iss_cnt <= '0;
            cap_cnt <= '0;
            vpipe   <= '0;
            rbuf    <= '0;
        end else if (rdy) begin
            vpipe <= (vpipe << 1) | RD_LAT'(issue && !store);
            if (accept) begin
                base    <= mem_addr_i;
                size    <= dec_size;
                uns     <= funct3_i[2];
                store   <= is_store;
                sdata   <= store_data_i;
                wd_q    <= wd_i;
                iss_cnt <= '0;
                cap_cnt <= '0;
            end
            if (issue) begin
                iss_cnt <= iss_cnt + CNT_W'(1);
            end
            if (capture) begin
                cap_cnt <= cap_cnt + CNT_W'(1);
                for (int i = 0; i < NB; i++) begin
                    if (cap_cnt == CNT_W'(i)) begin
                        rbuf[8*i +: 8] <= mem_data_i;
                    end
                end
            end
        end
    end

endmodule
